lin_interp_sched: RTL and testbench

//  Sequencer for the lin1D linear interpolator in the fractional upsampling (rate-conversion) path.
//  - Accepts an AXI-stream of packed IQ samples.
//  - Runs a programmable phase accumulator to produce the sample pair (in0, in1) and the Q15 weights (scale0, scale1) for each output beat.
//  - Replaces fixed 5-phase stepping with a settings-bus-programmed step, so any ratio 1..2^16 outputs per input is possible.

---
 rtl/lin_interp_sched.sv | 175 +++++++++++++++++
 tb/tb_lin_interp_sched.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lin_interp_sched.sv
// rtl/lin_interp_sched.sv - phase-accumulator sequencer feeding the lin1D interpolator
//
// Purpose:
//   Takes a stream of packed IQ samples and runs a programmable phase
//   accumulator. Each output beat carries the sample pair (in0 older, in1
//   newer) and the Q15 weights (scale0 on in0, scale1 on in1). The output
//   rate per input is set by STEP (1.0 = 2^PHASE_W).
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   set_stb/set_addr/set_data  settings bus (SR_BASE = step, SR_BASE+1 = ctrl)
//   in_tdata/tvalid/tlast/tready    input sample stream
//   in0_tdata, in1_tdata       sample pair to the interpolator
//   scale0_tdata, scale1_tdata Q15 weights
//   out_tvalid/tlast/tready    command beat handshake
//   rb_addr, rb_data           statistics readback
//
// Optional feature macro: LIN_SCHED_STATS_EN (beat/starve counters on rb_data).
module lin_interp_sched #(
  parameter int         DATA_WIDTH = 16,
  parameter int         PHASE_W    = 16,
  parameter logic [7:0] SR_BASE    = 8'd0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    set_stb,
  input  logic [7:0]              set_addr,
  input  logic [31:0]             set_data,
  input  logic [2*DATA_WIDTH-1:0] in_tdata,
  input  logic                    in_tvalid,
  input  logic                    in_tlast,
  output logic                    in_tready,
  output logic [2*DATA_WIDTH-1:0] in0_tdata,
  output logic [2*DATA_WIDTH-1:0] in1_tdata,
  output logic [DATA_WIDTH-1:0]   scale0_tdata,
  output logic [DATA_WIDTH-1:0]   scale1_tdata,
  output logic                    out_tvalid,
  output logic                    out_tlast,
  input  logic                    out_tready,
  input  logic [1:0]              rb_addr,
  output logic [31:0]             rb_data
);

  localparam logic [PHASE_W:0]      ONE     = {1'b1, {PHASE_W{1'b0}}};
  localparam logic [PHASE_W:0]      HALF    = {2'b01, {(PHASE_W-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] Q15_MAX = DATA_WIDTH'(32767);

  typedef enum logic [1:0] {S_PRIME0, S_PRIME1, S_RUN, S_FETCH} state_t;

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] ph_q;
  logic [PHASE_W:0]   step_q, pend_q, step_wr;
  logic               enable_q, last_q, single_q;
  logic [PHASE_W+1:0] sum;
  logic               wrap, wr_step, wr_ctrl, soft_clr, in_hs, out_hs;
  logic [DATA_WIDTH-1:0] frac;
  logic               unused_bits;

  assign wr_step  = set_stb && (set_addr == SR_BASE);
  assign wr_ctrl  = set_stb && (set_addr == SR_BASE + 8'd1);
  assign soft_clr = wr_ctrl && set_data[1];

  // Zero or anything above 1.0 would stall or skip samples, so both clamp to 1.0.
  assign step_wr = ((set_data[PHASE_W:0] == '0) || (set_data[PHASE_W:0] > ONE)) ?
                   ONE : set_data[PHASE_W:0];

  assign sum = {2'b00, ph_q} + {1'b0, step_q};
  // A lone-sample packet has nothing to interpolate towards, so its single
  // beat always counts as the wrap that ends the packet.
  assign wrap = single_q || (sum >= {1'b0, ONE});

  assign out_tvalid = (state_q == S_RUN);
  assign out_tlast  = out_tvalid && wrap && last_q;
  // Gated by reset so no upstream sample is consumed in a cycle reset discards.
  assign in_tready  = !reset && ((state_q == S_PRIME0) ? enable_q :
                                 ((state_q == S_PRIME1) || (state_q == S_FETCH)));
  assign in_hs  = in_tvalid && in_tready;
  assign out_hs = out_tvalid && out_tready;

  assign frac         = DATA_WIDTH'(ph_q[PHASE_W-1 -: 15]);
  assign scale1_tdata = out_tvalid ? frac : '0;
  assign scale0_tdata = out_tvalid ? (Q15_MAX - frac) : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_PRIME0: if (in_hs) state_d = in_tlast ? S_RUN : S_PRIME1;
      S_PRIME1: if (in_hs) state_d = S_RUN;
      S_RUN:    if (out_hs && wrap) state_d = last_q ? S_PRIME0 : S_FETCH;
      S_FETCH:  if (in_hs) state_d = S_RUN;
      default:  state_d = S_PRIME0;
    endcase
    if (soft_clr) state_d = S_PRIME0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_PRIME0;
      ph_q      <= '0;
      step_q    <= HALF;
      pend_q    <= HALF;
      enable_q  <= 1'b1;
      last_q    <= 1'b0;
      single_q  <= 1'b0;
      in0_tdata <= '0;
      in1_tdata <= '0;
    end else begin
      state_q <= state_d;
      if (wr_step) pend_q <= step_wr;
      if (wr_ctrl) enable_q <= set_data[0];
      if (soft_clr) begin
        ph_q      <= '0;
        last_q    <= 1'b0;
        single_q  <= 1'b0;
        in0_tdata <= '0;
        in1_tdata <= '0;
        step_q    <= pend_q;
      end else if (in_hs) begin
        last_q    <= in_tlast;
        in1_tdata <= in_tdata;
        if (state_q == S_PRIME0) begin
          // Loading in0 too makes a lone sample present as (x, x).
          in0_tdata <= in_tdata;
          single_q  <= in_tlast;
          ph_q      <= '0;
        end else begin
          in0_tdata <= in1_tdata;
          single_q  <= 1'b0;
        end
      end else if (out_hs) begin
        if (wrap && last_q) begin
          ph_q     <= '0;
          single_q <= 1'b0;
          step_q   <= pend_q;
        end else begin
          // Below 2.0, dropping the integer bit is the same as subtracting 1.0.
          ph_q <= sum[PHASE_W-1:0];
        end
      end
    end
  end

`ifdef LIN_SCHED_STATS_EN
  logic [31:0] in_cnt, out_cnt, starve_cnt;

  always_ff @(posedge clk) begin
    if (reset || soft_clr) begin
      in_cnt     <= '0;
      out_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      if (in_hs)  in_cnt  <= in_cnt + 32'd1;
      if (out_hs) out_cnt <= out_cnt + 32'd1;
      if (((state_q == S_PRIME1) || (state_q == S_FETCH)) && !in_tvalid)
        starve_cnt <= starve_cnt + 32'd1;
    end
  end

  always_comb begin
    rb_data = '0;
    case (rb_addr)
      2'd0:    rb_data = in_cnt;
      2'd1:    rb_data = out_cnt;
      2'd2:    rb_data = starve_cnt;
      default: rb_data = 32'(step_q);
    endcase
  end

  assign unused_bits = ^set_data[31:PHASE_W+1];
`else
  assign rb_data     = '0;
  assign unused_bits = ^{set_data[31:PHASE_W+1], rb_addr};
`endif

endmodule

// File: tb/tb_lin_interp_sched.sv
// tb/tb_lin_interp_sched.sv - self-checking bench for lin_interp_sched
module tb_lin_interp_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic [31:0] in_tdata = '0;
  logic        in_tvalid = 1'b0;
  logic        in_tlast = 1'b0;
  logic        in_tready;
  logic [31:0] in0_tdata, in1_tdata;
  logic [15:0] scale0_tdata, scale1_tdata;
  logic        out_tvalid, out_tlast;
  logic        out_tready = 1'b0;
  logic [1:0]  rb_addr = '0;
  logic [31:0] rb_data;

  always #5 clk = ~clk;

  lin_interp_sched dut (
    .clk(clk), .reset(reset),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready),
    .in0_tdata(in0_tdata), .in1_tdata(in1_tdata),
    .scale0_tdata(scale0_tdata), .scale1_tdata(scale1_tdata),
    .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tready(out_tready),
    .rb_addr(rb_addr), .rb_data(rb_data)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] s0;
    logic [15:0] s1;
    logic        l;
  } beat_t;

  typedef struct {int step; int n; int rmode; int first; int nb;} cfg_t;
  typedef struct {int ia; int ib; int s0; int s1; bit l;} vexp_t;

  int    n_chk = 0;
  int    n_pass = 0;
  int    rmode = 3;
  beat_t got[$];
  beat_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, req);
  endtask

  task automatic chk_beat(input string nm, input int idx, input beat_t act, input beat_t req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s beat %0d: got in0=%h in1=%h s0=%0d s1=%0d last=%0d expected in0=%h in1=%h s0=%0d s1=%0d last=%0d",
                  nm, idx, act.a, act.b, act.s0, act.s1, act.l, req.a, req.b, req.s0, req.s1, req.l);
  endtask

  function automatic logic [31:0] smp(input int pkt, input int i);
    logic [15:0] hi, lo;
    hi = 16'(pkt * 16 + i + 1);
    lo = 16'(pkt * 97 + i * 13) ^ 16'h5A5A;
    return {hi, lo};
  endfunction

  // Output beat j sits at absolute position j*STEP along the packet; the
  // integer part picks the sample pair, the fraction the weight.
  function automatic void model(input int pkt, input int n, input int step_raw);
    longint st, span;
    beat_t  bt;
    int     k, f;
    st = longint'(step_raw & 32'h1FFFF);
    if (st == 0 || st > 65536) st = 65536;
    if (n == 1) begin
      bt.a = smp(pkt, 0); bt.b = smp(pkt, 0); bt.s0 = 16'd32767; bt.s1 = 16'd0; bt.l = 1'b1;
      exp_q.push_back(bt);
      return;
    end
    span = longint'(n - 1) * 65536;
    for (longint t = 0; t < span; t += st) begin
      k = int'(t / 65536);
      f = int'(t % 65536);
      bt.a  = smp(pkt, k);
      bt.b  = smp(pkt, k + 1);
      bt.s1 = 16'(f / 2);
      bt.s0 = 16'(32767 - f / 2);
      bt.l  = (t + st >= span);
      exp_q.push_back(bt);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic [7:0] addr, input logic [31:0] data);
    set_stb = 1'b1; set_addr = addr; set_data = data;
    tick();
    set_stb = 1'b0;
  endtask

  task automatic program_step(input int step);
    set_wr(8'd0, step);
    set_wr(8'd1, 32'h3);
  endtask

  task automatic push(input logic [31:0] d, input bit last, input int gap);
    bit hs;
    int c;
    c = 0;
    in_tdata = d; in_tlast = last; in_tvalid = 1'b1;
    while (1) begin
      @(negedge clk);
      hs = in_tready;
      tick();
      if (hs) break;
      c++;
      if (c >= 300) begin
        n_chk++;
        $display("FAIL input_accept: got no handshake in %0d cycles, required one", c);
        break;
      end
    end
    if (gap > 0 || last) in_tvalid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_pkt(input int pkt, input int n, input int gapmax);
    for (int i = 0; i < n; i++)
      push(smp(pkt, i), (i == n - 1), (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
  endtask

  task automatic drain(input string nm);
    int budget;
    int ne;
    beat_t a, r;
    budget = 0;
    while (got.size() < exp_q.size() && budget < 3000) begin
      tick();
      budget++;
    end
    repeat (6) tick();
    ne = exp_q.size();
    chk({nm, "_count"}, 64'(got.size()), 64'(ne));
    while (got.size() > 0 && exp_q.size() > 0) begin
      a = got.pop_front();
      r = exp_q.pop_front();
      chk_beat(nm, ne - exp_q.size() - 1, a, r);
    end
    got.delete();
    exp_q.delete();
  endtask

  task automatic chk_stats(input string nm, input int ic, input int oc, input int sc, input int st);
`ifdef LIN_SCHED_STATS_EN
    @(negedge clk);
    rb_addr = 2'd0; #1; chk({nm, "_in_cnt"}, 64'(rb_data), 64'(ic));
    rb_addr = 2'd1; #1; chk({nm, "_out_cnt"}, 64'(rb_data), 64'(oc));
    rb_addr = 2'd2; #1; chk({nm, "_starve"}, 64'(rb_data), 64'(sc));
    rb_addr = 2'd3; #1; chk({nm, "_step"}, 64'(rb_data), 64'(st));
    tick();
`else
    @(negedge clk);
    rb_addr = 2'($urandom_range(0, 3)); #1;
    chk({nm, "_rb_zero"}, 64'(rb_data), 64'(ic - ic + oc - oc + sc - sc + st - st));
    tick();
`endif
  endtask

  // Output ready pattern: 0 always ready, 1 toggling, 2 random, 3 never.
  initial begin
    forever begin
      tick();
      case (rmode)
        0:       out_tready = 1'b1;
        1:       out_tready = ~out_tready;
        2:       out_tready = 1'($urandom_range(0, 1));
        default: out_tready = 1'b0;
      endcase
    end
  end

  // Beat collector and hold-while-stalled checker.
  initial begin
    bit    prev_stall, prev_clr;
    beat_t prev_b, cur;
    prev_stall = 1'b0;
    prev_clr   = 1'b0;
    prev_b     = '0;
    forever begin
      @(negedge clk);
      cur = {in0_tdata, in1_tdata, scale0_tdata, scale1_tdata, out_tlast};
      if (prev_stall && !prev_clr) begin
        n_chk++;
        if (out_tvalid && cur === prev_b) n_pass++;
        else $display("FAIL stall_hold: got valid=%0d beat=%h required valid=1 beat=%h", out_tvalid, cur, prev_b);
      end
      if (!reset && out_tvalid && out_tready) got.push_back(cur);
      prev_stall = !reset && out_tvalid && !out_tready;
      prev_b     = cur;
      prev_clr   = reset || (set_stb && set_addr == 8'd1 && set_data[1]);
    end
  end

  cfg_t  cfg[6];
  vexp_t vx[13];

  initial begin
    beat_t bt;
    int    step, n;

    cfg[0] = '{32'h8000, 3, 0, 0, 4};
    cfg[1] = '{32'h4000, 2, 0, 4, 4};
    cfg[2] = '{32'h10000, 5, 0, 8, 4};
    cfg[3] = '{0, 5, 0, 8, 4};
    cfg[4] = '{32'h8000, 3, 1, 0, 4};
    cfg[5] = '{32'h8000, 1, 2, 12, 1};
    vx[0]  = '{0, 1, 32767, 0, 0};
    vx[1]  = '{0, 1, 16383, 16384, 0};
    vx[2]  = '{1, 2, 32767, 0, 0};
    vx[3]  = '{1, 2, 16383, 16384, 1};
    vx[4]  = '{0, 1, 32767, 0, 0};
    vx[5]  = '{0, 1, 24575, 8192, 0};
    vx[6]  = '{0, 1, 16383, 16384, 0};
    vx[7]  = '{0, 1, 8191, 24576, 1};
    vx[8]  = '{0, 1, 32767, 0, 0};
    vx[9]  = '{1, 2, 32767, 0, 0};
    vx[10] = '{2, 3, 32767, 0, 0};
    vx[11] = '{3, 4, 32767, 0, 1};
    vx[12] = '{0, 0, 32767, 0, 1};

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_tvalid", 64'(out_tvalid), 64'd0);
    chk("rst_out_tlast", 64'(out_tlast), 64'd0);
    chk("rst_in0", 64'(in0_tdata), 64'd0);
    chk("rst_in1", 64'(in1_tdata), 64'd0);
    chk("rst_scale0", 64'(scale0_tdata), 64'd0);
    chk("rst_scale1", 64'(scale1_tdata), 64'd0);
    chk("rst_in_tready", 64'(in_tready), 64'd1);
    tick();
    chk_stats("rst", 0, 0, 0, 32'h8000);

    for (int t = 0; t < 6; t++) begin
      rmode = cfg[t].rmode;
      program_step(cfg[t].step);
      for (int j = 0; j < cfg[t].nb; j++) begin
        bt.a  = smp(t, vx[cfg[t].first + j].ia);
        bt.b  = smp(t, vx[cfg[t].first + j].ib);
        bt.s0 = 16'(vx[cfg[t].first + j].s0);
        bt.s1 = 16'(vx[cfg[t].first + j].s1);
        bt.l  = vx[cfg[t].first + j].l;
        exp_q.push_back(bt);
      end
      send_pkt(t, cfg[t].n, 0);
      drain($sformatf("tbl%0d", t));
      chk_stats($sformatf("tbl%0d", t), cfg[t].n, cfg[t].nb, 0,
                (cfg[t].step == 0) ? 32'h10000 : cfg[t].step);
    end

    // New step written mid-packet applies from the next packet.
    rmode = 0;
    program_step(32'h8000);
    model(20, 3, 32'h8000);
    model(21, 2, 32'h4000);
    fork
      send_pkt(20, 3, 0);
      begin repeat (3) tick(); set_wr(8'd0, 32'h4000); end
    join
    send_pkt(21, 2, 0);
    drain("step_midpkt");

    // Disable mid-packet lets the packet finish, then blocks input.
    program_step(32'h8000);
    model(30, 3, 32'h8000);
    fork
      send_pkt(30, 3, 0);
      begin repeat (2) tick(); set_wr(8'd1, 32'h0); end
    join
    drain("dis_midpkt");
    @(negedge clk);
    chk("disabled_tready", 64'(in_tready), 64'd0);
    tick();
    set_wr(8'd1, 32'h1);
    @(negedge clk);
    chk("enabled_tready", 64'(in_tready), 64'd1);
    tick();

    // Soft clear while a beat is stalled in S_RUN.
    rmode = 3;
    program_step(32'h4000);
    send_pkt(40, 2, 0);
    @(negedge clk);
    chk("clr_run_valid", 64'(out_tvalid), 64'd1);
    tick();
    set_wr(8'd1, 32'h3);
    @(negedge clk);
    chk("clr_out_tvalid", 64'(out_tvalid), 64'd0);
    chk("clr_out_tlast", 64'(out_tlast), 64'd0);
    chk("clr_in_tready", 64'(in_tready), 64'd1);
    tick();
    chk_stats("clr", 0, 0, 0, 32'h4000);
    rmode = 0;
    drain("clr_nobeats");
    model(41, 2, 32'h4000);
    send_pkt(41, 2, 0);
    drain("after_clr");

    // Reset mid-packet discards the packet and restores defaults.
    rmode = 3;
    program_step(32'h4000);
    push(smp(50, 0), 1'b0, 0);
    push(smp(50, 1), 1'b0, 0);
    in_tvalid = 1'b0;
    @(negedge clk);
    chk("rstmid_run_valid", 64'(out_tvalid), 64'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_out_tvalid", 64'(out_tvalid), 64'd0);
    chk("rstmid_in0", 64'(in0_tdata), 64'd0);
    chk("rstmid_scale0", 64'(scale0_tdata), 64'd0);
    chk("rstmid_in_tready", 64'(in_tready), 64'd1);
    tick();
    chk_stats("rstmid", 0, 0, 0, 32'h8000);
    rmode = 0;
    drain("rstmid_nobeats");
    model(51, 2, 32'h8000);
    send_pkt(51, 2, 0);
    drain("after_rstmid");

    // Random steps, packet lengths, input gaps and output back-pressure.
    for (int r = 0; r < 14; r++) begin
      case ($urandom_range(0, 3))
        0:       step = 0;
        1:       step = 32'h10000 + int'($urandom_range(1, 32'hFFFF));
        default: step = int'($urandom_range(32'h800, 32'h10000));
      endcase
      n = int'($urandom_range(1, 6));
      rmode = int'($urandom_range(0, 2));
      program_step(step);
      model(60 + r, n, step);
      send_pkt(60 + r, n, 2);
      drain($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
